// File: rtl/usm_avmm_page_splitter.sv
// Splits USM Avalon-MM bursts so no downstream burst crosses a page or exceeds MAX_BURST beats.
// Read returns and write data pass straight through; only command framing is rewritten.
module usm_avmm_page_splitter #(
   parameter int unsigned ADDR_WIDTH       = 48,
   parameter int unsigned DATA_WIDTH       = 512,
   parameter int unsigned BURSTCOUNT_WIDTH = 5,
   parameter int unsigned PAGE_BYTES       = 4096,
   parameter int unsigned MAX_BURST        = 16,
   parameter int unsigned PEND_WIDTH       = 12
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [ADDR_WIDTH-1:0]       s_address,
   input  logic [BURSTCOUNT_WIDTH-1:0] s_burstcount,
   input  logic                        s_read,
   input  logic                        s_write,
   input  logic [DATA_WIDTH-1:0]       s_writedata,
   input  logic [DATA_WIDTH/8-1:0]     s_byteenable,
   output logic                        s_waitrequest,
   output logic [DATA_WIDTH-1:0]       s_readdata,
   output logic                        s_readdatavalid,
   output logic [ADDR_WIDTH-1:0]       m_address,
   output logic [BURSTCOUNT_WIDTH-1:0] m_burstcount,
   output logic                        m_read,
   output logic                        m_write,
   output logic [DATA_WIDTH-1:0]       m_writedata,
   output logic [DATA_WIDTH/8-1:0]     m_byteenable,
   input  logic                        m_waitrequest,
   input  logic [DATA_WIDTH-1:0]       m_readdata,
   input  logic                        m_readdatavalid,
   output logic                        busy,
   output logic [PEND_WIDTH-1:0]       rd_beats_pending,
   output logic [31:0]                 stat_splits
);

   localparam int unsigned BYTES      = DATA_WIDTH / 8;
   localparam int unsigned BYTE_LOG   = $clog2(BYTES);
   localparam int unsigned PAGE_BEATS = PAGE_BYTES / BYTES;
   localparam int unsigned BC_W       = BURSTCOUNT_WIDTH;
   localparam int unsigned PW1        = PEND_WIDTH + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [BC_W-1:0]         rem_q, rem_d;
   logic [BC_W-1:0]         len_q, len_d;
   logic [BC_W-1:0]         beat_cnt_q, beat_cnt_d;
   logic [PEND_WIDTH-1:0]   pend_q, pend_d;
   logic [31:0]             splits_q, splits_d;

   logic [ADDR_WIDTH-1:0]   addr_nxt;
   logic [BC_W-1:0]         rem_nxt;
   logic [BC_W-1:0]         cnt_nxt;
   logic [BC_W-1:0]         pend_inc;
   logic [PW1-1:0]          pend_wide;

   // Beats until the next page edge, clipped by remaining beats and MAX_BURST.
   function automatic logic [BC_W-1:0] calc_len(input logic [ADDR_WIDTH-1:0] a,
                                                input logic [BC_W-1:0]       r);
      logic [ADDR_WIDTH-1:0] off;
      logic [ADDR_WIDTH-1:0] room;
      logic [ADDR_WIDTH-1:0] l;
      off  = (a >> BYTE_LOG) & ADDR_WIDTH'(PAGE_BEATS - 1);
      room = ADDR_WIDTH'(PAGE_BEATS) - off;
      l    = ADDR_WIDTH'(r);
      if (l > ADDR_WIDTH'(MAX_BURST)) l = ADDR_WIDTH'(MAX_BURST);
      if (l > room) l = room;
      return BC_W'(l);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         len_q      <= '0;
         beat_cnt_q <= '0;
         pend_q     <= '0;
         splits_q   <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         len_q      <= len_d;
         beat_cnt_q <= beat_cnt_d;
         pend_q     <= pend_d;
         splits_q   <= splits_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      rem_d         = rem_q;
      len_d         = len_q;
      beat_cnt_d    = beat_cnt_q;
      splits_d      = splits_q;
      pend_inc      = '0;
      rem_nxt       = rem_q;
      cnt_nxt       = beat_cnt_q;
      addr_nxt      = addr_q + (ADDR_WIDTH'(len_q) << BYTE_LOG);
      s_waitrequest = 1'b1;
      m_read        = 1'b0;
      m_write       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (s_read || s_write) begin
               addr_d     = s_address;
               rem_d      = s_burstcount;
               len_d      = calc_len(s_address, s_burstcount);
               beat_cnt_d = '0;
               state_d    = s_read ? ST_RD : ST_WR;
            end
         end
         ST_RD: begin
            m_read = 1'b1;
            if (!m_waitrequest) begin
               rem_nxt  = rem_q - len_q;
               addr_d   = addr_nxt;
               rem_d    = rem_nxt;
               pend_inc = len_q;
               if (rem_nxt != '0) begin
                  len_d = calc_len(addr_nxt, rem_nxt);
                  if (splits_q != '1) splits_d = splits_q + 32'd1;
               end else begin
                  s_waitrequest = 1'b0;
                  state_d       = ST_IDLE;
               end
            end
         end
         ST_WR: begin
            m_write       = s_write;
            s_waitrequest = m_waitrequest;
            if (s_write && !m_waitrequest) begin
               rem_nxt = rem_q - BC_W'(1);
               cnt_nxt = beat_cnt_q + BC_W'(1);
               rem_d   = rem_nxt;
               if (cnt_nxt == len_q) begin
                  // Sub-burst complete: advance to the next sub-burst header.
                  addr_d     = addr_nxt;
                  beat_cnt_d = '0;
                  if (rem_nxt != '0) begin
                     len_d = calc_len(addr_nxt, rem_nxt);
                     if (splits_q != '1) splits_d = splits_q + 32'd1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  beat_cnt_d = cnt_nxt;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Issue and return in one cycle net out to len-1.
      pend_wide = PW1'(pend_q) + PW1'(pend_inc) - PW1'(m_readdatavalid);
      pend_d    = pend_wide[PEND_WIDTH-1:0];
   end

   assign m_address        = addr_q;
   assign m_burstcount     = len_q;
   assign m_writedata      = s_writedata;
   assign m_byteenable     = s_byteenable;
   assign s_readdata       = m_readdata;
   assign s_readdatavalid  = m_readdatavalid;
   assign busy             = (state_q != ST_IDLE);
   assign rd_beats_pending = pend_q;
   assign stat_splits      = splits_q;

   always @(posedge clk) begin
      if (!reset) begin
         if (state_q == ST_IDLE && (s_read || s_write))
            assert (s_burstcount != '0) else $error("illegal zero burstcount");
         assert (!pend_wide[PEND_WIDTH]) else $error("rd_beats_pending out of range");
      end
   end

endmodule
